i2c_eeprom_master: RTL and testbench
====================================

# i2c_eeprom_master

Synthesizable single-clock I2C bus master that performs single-byte random writes and random reads on an AT24C02/4/8/16-class EEPROM, using 11-bit addressing. The host side is a start-pulse/done-pulse interface. The bus side drives `scl` and an open-drain `sda`. It is the initiator paired with the behavioural EEPROM model in the I2C testbench, and it must interoperate with that model bit-for-bit.

## Interface
- `CLK_DIV`, default 125: `clk` cycles per SCL quarter-phase. The SCL period is 4*CLK_DIV cycles (100 kHz at 50 MHz). CLK_DIV*Tclk must be ≥ 200 ns.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_wr`  in  1  one-cycle pulse that starts a random write; sampled only when `busy`=0.
- `start_rd`  in  1  one-cycle pulse that starts a random read; sampled only when `busy`=0.
- `addr`  in  11  byte address; bits [10:8] form the block-select bits of the control byte. Latched at start.
- `wdata`  in  8  write byte; latched at start.
- `rdata`  out  8  last byte read; held until the next read completes.
- `busy`  out  1  high from the cycle after an accepted start until the cycle after `done`.
- `done`  out  1  one-cycle completion pulse, for success or error.
- `ack_err`  out  1  set with `done` if any slave ACK slot sampled high; cleared on the next accepted start.
- `scl`  out  1  push-pull serial clock; 1 when idle.
- `sda`  inout  1  open-drain: the block drives 1'b0 or 1'bz, never 1. An external pull-up is required.

## Operation
- Control bytes: write = {4'b1010, addr[10:8], 1'b0}; read = {4'b1010, addr[10:8], 1'b1}.
- Write sequence: START, ctrl_w, ACK, addr[7:0], ACK, wdata, ACK, STOP.
- Read sequence: START, ctrl_w, ACK, addr[7:0], ACK, repeated START, ctrl_r, ACK, 8 data bits, master NACK (sda released), STOP.
- Bits are sent MSB first.
- FSM states: IDLE, START, CTRL_W, ADDR, WDATA, RSTART, CTRL_R, RDATA, MNACK, STOP, FINISH.
  - Each byte state covers 9 bit slots: 8 data bits plus the ACK slot. A 4-bit slot counter runs 0..8.
- Transitions:
  - IDLE→START on an accepted start.
  - START→CTRL_W→ADDR.
  - ADDR→WDATA for a write; ADDR→RSTART→CTRL_R→RDATA for a read.
  - WDATA→STOP. RDATA→MNACK→STOP.
  - STOP→FINISH (asserts `done`)→IDLE.
- ACK check: `sda` is sampled at Q3 of each slave ACK slot. A sample of 1 sets `ack_err` and the FSM jumps directly to STOP.
- `start_wr` and `start_rd` in the same cycle: the write wins and the read is dropped.
- Starts while `busy`=1 are ignored; no queueing.
- `reset` at any point, mid-transfer included:
  - Next cycle: `scl`=1, `sda` released, state IDLE.
  - `busy`, `done`, and `ack_err` go to 0; `rdata` goes to 8'h00.
  - No STOP is generated.

## Timing
- Every bit slot is four quarter-phases Q0..Q3 of CLK_DIV cycles each.
- Data slots:
  - `scl`=0 in Q0/Q1, `scl`=1 in Q2/Q3.
  - The master changes `sda` only at the start of Q1, which is mid-low and ≥100 ns after SCL falls, honouring the slave's output hold.
  - The master samples `sda` at the start of Q3.
- START/RSTART slot:
  - `scl` low in Q0/Q1; `sda` released at Q1; `scl` high at Q2.
  - `sda` pulled low at Q3 with `scl` high.
- STOP slot:
  - `sda` pulled low at Q1; `scl` high at Q2.
  - `sda` released at Q3; `scl` stays 1.
- ACK and RDATA slots: the master releases `sda` at Q1 of the slot. MNACK slot: `sda` stays released.
- Write latency: 29 slots (116*CLK_DIV cycles) from acceptance to the `done` cycle, ±1 cycle of pipeline. The count is START 1 + 3×9 + STOP 1.
- Read latency: 39 slots (156*CLK_DIV cycles). The count is START 1 + 2×9 + RSTART 1 + 9 + 9 + STOP 1.
- `rdata` updates in the same cycle that `done` rises.

## Structure
- Shared package/header `i2c_pkg` holds:
  - the FSM state encodings;
  - `I2C_DEV_TYPE` = 4'b1010;
  - the quarter-phase encoding;
  - the slot-count constants (BYTE_SLOTS = 9).
- Sub-module `i2c_bit_timer` owns the CLK_DIV counter and the 2-bit quarter-phase counter.
  - Outputs: one-cycle `q_tick` strobes plus `q_phase`.
  - It is reset by `reset` and by a `restart` input from the FSM.
- The top level holds the FSM, the 8-bit shift register, the slot counter, and the `scl`/`sda_oe` registers. `sda` = `sda_oe` ? 1'b0 : 1'bz.

## Test plan
- Write addr 11'h5A7 with data 8'hC3, EEPROM model attached → model reports memory[5a7]=c3; one `done` pulse; `ack_err`=0; latency 116*CLK_DIV ±1 cycles.
- Then read addr 11'h5A7 → `rdata`=8'hC3; `ack_err`=0; bus sequence includes a repeated START and a final NACK; `scl`=1 and `sda`=z afterwards.
- Boundary addresses: write 8'h01 to 11'h000 and 8'hFE to 11'h7FF, then read both back → 8'h01 and 8'hFE; block bits are 3'b000 and 3'b111 on the wire.
- Same-cycle collisions:
  - `start_wr` and `start_rd` asserted together → exactly one transaction, a write.
  - `start_rd` pulsed while `busy` → ignored; exactly one `done`.
- No slave, pull-up only → `ack_err`=1 at `done` after the ctrl byte's ACK slot; a STOP is observed; total time is 11 slots (START 1 + 9 + STOP 1).
- `reset` asserted mid-ADDR byte → next cycle `scl`=1, `sda`=z, `busy`=0, `rdata`=8'h00; a subsequent write of 8'h3C to 11'h010 completes correctly.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C EEPROM master: FSM states, device type,
// quarter-phase encoding and slot-count constants.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_CTRL_W,
      ST_ADDR,
      ST_WDATA,
      ST_RSTART,
      ST_CTRL_R,
      ST_RDATA,
      ST_MNACK,
      ST_STOP,
      ST_FINISH
   } i2c_state_t;

   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } q_phase_t;

   localparam logic [3:0] I2C_DEV_TYPE = 4'b1010;
   localparam logic [3:0] BYTE_SLOTS   = 4'd9;
   localparam logic [3:0] ACK_SLOT     = BYTE_SLOTS - 4'd1;
   localparam logic [3:0] RDATA_LAST   = 4'd7;

   function automatic logic [7:0] ctrl_byte(input logic [2:0] blk, input logic rd);
      return {I2C_DEV_TYPE, blk, rd};
   endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-phase timebase: CLK_DIV down-counter with terminal-count strobe and
// a 2-bit quarter-phase counter, both restartable by the FSM.
module i2c_bit_timer
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 125
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     restart,
   output logic     q_tick,
   output q_phase_t q_phase
);

   localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign q_tick = (cnt == '0);

   always_ff @(posedge clk) begin
      if (reset || restart) begin
         cnt     <= RELOAD;
         q_phase <= Q0;
      end else if (q_tick) begin
         cnt     <= RELOAD;
         q_phase <= q_phase_t'(q_phase + 2'd1);
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/i2c_eeprom_master.sv
// I2C master for 24Cxx-class EEPROMs: single-byte random write and random read
// with 11-bit addressing, push-pull SCL and open-drain SDA.
//
// state  | meaning
// IDLE   | bus idle, waiting for start_wr / start_rd
// START  | start condition slot
// CTRL_W | control byte with R/W=0 plus slave ACK
// ADDR   | low address byte plus slave ACK
// WDATA  | write data byte plus slave ACK
// RSTART | repeated start slot
// CTRL_R | control byte with R/W=1 plus slave ACK
// RDATA  | 8 data bits driven by the slave
// MNACK  | master NACK slot, SDA released
// STOP   | stop condition slot
// FINISH | one-cycle done pulse
module i2c_eeprom_master
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 125
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_wr,
   input  logic        start_rd,
   input  logic [10:0] addr,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        busy,
   output logic        done,
   output logic        ack_err,
   output logic        scl,
   inout  wire         sda
);

   i2c_state_t  state, state_d;
   q_phase_t    q_phase;
   logic        q_tick, timer_restart, run, slot_end;
   logic        is_tx_byte, start_acc, rd_op;
   logic        sda_oe, sda_oe_q1, sda_smp;
   logic [3:0]  slot;
   logic [7:0]  shift, wdata_q;
   logic [10:0] addr_q;

   assign timer_restart = (state == ST_IDLE);

   i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
      .clk     (clk),
      .reset   (reset),
      .restart (timer_restart),
      .q_tick  (q_tick),
      .q_phase (q_phase)
   );

   assign run        = q_tick && !(state inside {ST_IDLE, ST_FINISH});
   assign slot_end   = run && (q_phase == Q3);
   assign is_tx_byte = state inside {ST_CTRL_W, ST_ADDR, ST_WDATA, ST_CTRL_R};
   assign start_acc  = (state == ST_IDLE) && (start_wr || start_rd);
   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_FINISH);
   assign sda        = sda_oe ? 1'b0 : 1'bz;

   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE:   if (start_wr || start_rd) state_d = ST_START;
         ST_START:  if (slot_end) state_d = ST_CTRL_W;
         ST_CTRL_W, ST_ADDR, ST_WDATA, ST_CTRL_R: begin
            if (slot_end && slot == ACK_SLOT) begin
               if (sda_smp) begin
                  state_d = ST_STOP;
               end else begin
                  case (state)
                     ST_CTRL_W: state_d = ST_ADDR;
                     ST_ADDR:   state_d = rd_op ? ST_RSTART : ST_WDATA;
                     ST_CTRL_R: state_d = ST_RDATA;
                     default:   state_d = ST_STOP;
                  endcase
               end
            end
         end
         ST_RSTART: if (slot_end) state_d = ST_CTRL_R;
         ST_RDATA:  if (slot_end && slot == RDATA_LAST) state_d = ST_MNACK;
         ST_MNACK:  if (slot_end) state_d = ST_STOP;
         ST_STOP:   if (slot_end) state_d = ST_FINISH;
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // SDA level to present at the start of Q1 (mid-low) of the current slot
   always_comb begin
      sda_oe_q1 = 1'b0;
      if (state == ST_STOP)
         sda_oe_q1 = 1'b1;
      else if (is_tx_byte && slot != ACK_SLOT)
         sda_oe_q1 = ~shift[7];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         slot    <= '0;
         shift   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_op   <= 1'b0;
         ack_err <= 1'b0;
         rdata   <= '0;
         scl     <= 1'b1;
         sda_oe  <= 1'b0;
         sda_smp <= 1'b0;
      end else begin
         state <= state_d;
         if (start_acc) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            rd_op   <= ~start_wr;
            ack_err <= 1'b0;
            scl     <= 1'b0;
         end
         if (run) begin
            case (q_phase)
               Q0: sda_oe <= sda_oe_q1;
               Q1: scl <= 1'b1;
               Q2: begin
                  sda_smp <= sda;
                  if (state == ST_RDATA) shift <= {shift[6:0], sda};
                  if (state inside {ST_START, ST_RSTART}) sda_oe <= 1'b1;
                  if (state == ST_STOP) sda_oe <= 1'b0;
               end
               Q3: scl <= (state == ST_STOP);
            endcase
         end
         if (slot_end) begin
            if ((is_tx_byte && slot != ACK_SLOT) || (state == ST_RDATA && slot != RDATA_LAST))
               slot <= slot + 4'd1;
            else
               slot <= '0;
            if (is_tx_byte) shift <= {shift[6:0], 1'b0};
            if (state_d != state) begin
               case (state_d)
                  ST_CTRL_W: shift <= ctrl_byte(addr_q[10:8], 1'b0);
                  ST_ADDR:   shift <= addr_q[7:0];
                  ST_WDATA:  shift <= wdata_q;
                  ST_CTRL_R: shift <= ctrl_byte(addr_q[10:8], 1'b1);
                  default:   ;
               endcase
            end
            if (is_tx_byte && slot == ACK_SLOT && sda_smp) ack_err <= 1'b1;
            if (state == ST_STOP && rd_op && !ack_err) rdata <= shift;
         end
      end
   end

endmodule

// File: tb/tb_i2c_eeprom_master.sv
// Directed and randomized bench for i2c_eeprom_master with a behavioural
// 24Cxx EEPROM slave on an open-drain SDA line with pull-up.
`timescale 1ns/1ps
module tb_i2c_eeprom_master;

   localparam int CLK_DIV = 4;
   localparam int WR_LAT  = 29 * 4 * CLK_DIV;
   localparam int RD_LAT  = 39 * 4 * CLK_DIV;
   localparam int NS_LAT  = 11 * 4 * CLK_DIV;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_wr = 1'b0;
   logic        start_rd = 1'b0;
   logic [10:0] addr = '0;
   logic [7:0]  wdata = '0;
   logic [7:0]  rdata;
   logic        busy, done, ack_err, scl;
   tri1         sda;

   logic slave_oe = 1'b0;
   logic slave_en = 1'b1;
   assign sda = slave_oe ? 1'b0 : 1'bz;

   int n_assert = 0;
   int n_fail   = 0;

   i2c_eeprom_master #(.CLK_DIV(CLK_DIV)) dut (
      .clk      (clk),
      .reset    (reset),
      .start_wr (start_wr),
      .start_rd (start_rd),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .busy     (busy),
      .done     (done),
      .ack_err  (ack_err),
      .scl      (scl),
      .sda      (sda)
   );

   always #30 clk = ~clk;

   // behavioural EEPROM slave, sampled on the falling system clock edge
   logic [7:0]  mem [2048];
   logic [7:0]  ref_mem [2048];
   logic [7:0]  ctrl_q [$];
   logic [7:0]  shreg = '0, txb = '0;
   logic [2:0]  blk = '0;
   logic [10:0] ptr = '0;
   logic        prev_scl = 1'b1, prev_sda = 1'b1;
   logic        in_frame = 1'b0, rd_mode = 1'b0, go_read = 1'b0, nack_seen = 1'b0;
   int          bitcnt = 0, byte_n = 0, n_start = 0, n_stop = 0;

   task automatic slave_step();
      logic s, c, ack;
      s = sda;
      c = scl;
      ack = 1'b0;
      if (prev_scl === 1'b1 && c === 1'b1 && prev_sda === 1'b1 && s === 1'b0) begin
         n_start++;
         in_frame = 1'b1; bitcnt = 0; byte_n = 0; rd_mode = 1'b0; go_read = 1'b0; slave_oe = 1'b0;
      end else if (prev_scl === 1'b1 && c === 1'b1 && prev_sda === 1'b0 && s === 1'b1) begin
         n_stop++;
         in_frame = 1'b0; rd_mode = 1'b0; slave_oe = 1'b0;
      end else if (in_frame && prev_scl === 1'b0 && c === 1'b1) begin
         if (bitcnt < 8) begin
            if (!rd_mode) shreg = {shreg[6:0], s};
         end else if (bitcnt == 8 && rd_mode) begin
            if (s) begin
               nack_seen = 1'b1;
               go_read = 1'b0;
            end else begin
               ptr = ptr + 11'd1;
            end
         end
         bitcnt++;
      end else if (in_frame && prev_scl === 1'b1 && c === 1'b0) begin
         if (bitcnt == 9) begin
            bitcnt = 0;
            slave_oe = 1'b0;
            rd_mode = go_read;
            if (go_read) begin
               txb = mem[ptr];
               slave_oe = slave_en && !txb[7];
            end
         end else if (bitcnt == 8) begin
            if (rd_mode) begin
               slave_oe = 1'b0;
            end else begin
               if (byte_n == 0) begin
                  ctrl_q.push_back(shreg);
                  if (shreg[7:4] == 4'b1010) begin
                     ack = 1'b1;
                     blk = shreg[3:1];
                     go_read = shreg[0];
                  end
               end else if (byte_n == 1) begin
                  ptr = {blk, shreg};
                  ack = 1'b1;
               end else begin
                  mem[ptr] = shreg;
                  ptr = ptr + 11'd1;
                  ack = 1'b1;
               end
               byte_n++;
               slave_oe = slave_en && ack;
            end
         end else if (rd_mode && bitcnt >= 1 && bitcnt <= 7) begin
            slave_oe = slave_en && !txb[3'(7 - bitcnt)];
         end
      end
      prev_scl = c;
      prev_sda = s;
   endtask

   initial forever begin
      @(negedge clk);
      slave_step();
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_lat(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs >= exp - 1 && obs <= exp + 1) else begin
         n_fail++;
         $error("FAIL %s: observed %0d cycles expected %0d +/-1", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ctrl_at(input int i);
      return (i < ctrl_q.size()) ? ctrl_q[i] : 8'hxx;
   endfunction

   // one complete transaction: drive start, wait for done, check timing and idle bus
   task automatic run_txn(input string tag, input logic wr, input logic rd,
                          input logic [10:0] a, input logic [7:0] d, input int exp_lat,
                          input logic exp_err, input int pulse_rd_at, output logic [7:0] rv);
      int lat, ndone;
      bit got;
      ctrl_q.delete();
      n_start = 0; n_stop = 0; nack_seen = 1'b0;
      @(negedge clk);
      start_wr = wr; start_rd = rd; addr = a; wdata = d;
      @(posedge clk); #1;
      start_wr = 1'b0; start_rd = 1'b0;
      chk({tag, "/busy_on"}, 32'(busy), 32'd1);
      chk({tag, "/err_clr"}, 32'(ack_err), 32'd0);
      lat = 0; got = 1'b0;
      while (!got && lat < 2000) begin
         @(posedge clk); #1;
         lat++;
         start_rd = (lat == pulse_rd_at);
         if (done) got = 1'b1;
      end
      start_rd = 1'b0;
      rv = rdata;
      chk({tag, "/done_seen"}, 32'(got), 32'd1);
      chk_lat({tag, "/latency"}, lat, exp_lat);
      chk({tag, "/ack_err"}, 32'(ack_err), 32'(exp_err));
      ndone = 1;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk({tag, "/done_cnt"}, 32'(ndone), 32'd1);
      chk({tag, "/busy_off"}, 32'(busy), 32'd0);
      chk({tag, "/scl_idle"}, 32'(scl), 32'd1);
      chk({tag, "/sda_idle"}, 32'(sda), 32'd1);
      chk({tag, "/stops"}, 32'(n_stop), 32'd1);
   endtask

   initial begin
      logic [7:0]  rv, last_rd, d;
      logic [10:0] a;
      bit          do_rd;

      for (int i = 0; i < 2048; i++) begin
         mem[i]     = 8'(i * 7 + 3);
         ref_mem[i] = 8'(i * 7 + 3);
      end
      last_rd = 8'h00;

      repeat (5) @(posedge clk);
      #1;
      chk("rst/scl", 32'(scl), 32'd1);
      chk("rst/sda", 32'(sda), 32'd1);
      chk("rst/busy", 32'(busy), 32'd0);
      chk("rst/done", 32'(done), 32'd0);
      chk("rst/ack_err", 32'(ack_err), 32'd0);
      chk("rst/rdata", 32'(rdata), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      run_txn("wr_5a7", 1'b1, 1'b0, 11'h5A7, 8'hC3, WR_LAT, 1'b0, -1, rv);
      ref_mem[11'h5A7] = 8'hC3;
      chk("wr_5a7/mem", 32'(mem[11'h5A7]), 32'hC3);
      chk("wr_5a7/nctrl", 32'(ctrl_q.size()), 32'd1);
      chk("wr_5a7/ctrl", 32'(ctrl_at(0)), 32'hAA);
      chk("wr_5a7/starts", 32'(n_start), 32'd1);

      run_txn("rd_5a7", 1'b0, 1'b1, 11'h5A7, 8'h00, RD_LAT, 1'b0, -1, rv);
      last_rd = ref_mem[11'h5A7];
      chk("rd_5a7/rdata", 32'(rv), 32'(last_rd));
      chk("rd_5a7/starts", 32'(n_start), 32'd2);
      chk("rd_5a7/nack", 32'(nack_seen), 32'd1);
      chk("rd_5a7/ctrl_r", 32'(ctrl_at(1)), 32'hAB);

      run_txn("wr_000", 1'b1, 1'b0, 11'h000, 8'h01, WR_LAT, 1'b0, -1, rv);
      ref_mem[11'h000] = 8'h01;
      chk("wr_000/ctrl", 32'(ctrl_at(0)), 32'hA0);
      run_txn("wr_7ff", 1'b1, 1'b0, 11'h7FF, 8'hFE, WR_LAT, 1'b0, -1, rv);
      ref_mem[11'h7FF] = 8'hFE;
      chk("wr_7ff/ctrl", 32'(ctrl_at(0)), 32'hAE);
      run_txn("rd_000", 1'b0, 1'b1, 11'h000, 8'h00, RD_LAT, 1'b0, -1, rv);
      chk("rd_000/rdata", 32'(rv), 32'h01);
      chk("rd_000/ctrl_r", 32'(ctrl_at(1)), 32'hA1);
      run_txn("rd_7ff", 1'b0, 1'b1, 11'h7FF, 8'h00, RD_LAT, 1'b0, -1, rv);
      chk("rd_7ff/rdata", 32'(rv), 32'hFE);
      chk("rd_7ff/ctrl_r", 32'(ctrl_at(1)), 32'hAF);
      last_rd = 8'hFE;

      run_txn("collide", 1'b1, 1'b1, 11'h234, 8'h5D, WR_LAT, 1'b0, -1, rv);
      ref_mem[11'h234] = 8'h5D;
      chk("collide/nctrl", 32'(ctrl_q.size()), 32'd1);
      chk("collide/mem", 32'(mem[11'h234]), 32'h5D);

      run_txn("rd_busy", 1'b1, 1'b0, 11'h456, 8'h99, WR_LAT, 1'b0, 50, rv);
      ref_mem[11'h456] = 8'h99;
      chk("rd_busy/nctrl", 32'(ctrl_q.size()), 32'd1);

      slave_en = 1'b0;
      run_txn("noslave_wr", 1'b1, 1'b0, 11'h321, 8'h44, NS_LAT, 1'b1, -1, rv);
      chk("noslave_wr/mem", 32'(mem[11'h321]), 32'(ref_mem[11'h321]));
      run_txn("noslave_rd", 1'b0, 1'b1, 11'h321, 8'h00, NS_LAT, 1'b1, -1, rv);
      chk("noslave_rd/rdata_held", 32'(rv), 32'(last_rd));
      slave_en = 1'b1;

      for (int k = 0; k < 10; k++) begin
         do_rd = 1'($urandom_range(0, 1));
         a = 11'($urandom_range(0, 2047));
         d = 8'($urandom);
         if (do_rd) begin
            run_txn("rand_rd", 1'b0, 1'b1, a, d, RD_LAT, 1'b0, -1, rv);
            last_rd = ref_mem[a];
            chk("rand_rd/rdata", 32'(rv), 32'(last_rd));
            chk("rand_rd/ctrl_r", 32'(ctrl_at(1)), 32'({4'b1010, a[10:8], 1'b1}));
         end else begin
            run_txn("rand_wr", 1'b1, 1'b0, a, d, WR_LAT, 1'b0, -1, rv);
            ref_mem[a] = d;
            chk("rand_wr/mem", 32'(mem[a]), 32'(d));
            chk("rand_wr/ctrl", 32'(ctrl_at(0)), 32'({4'b1010, a[10:8], 1'b0}));
         end
      end

      run_txn("rd_pre_rst", 1'b0, 1'b1, 11'h5A7, 8'h00, RD_LAT, 1'b0, -1, rv);
      chk("rd_pre_rst/rdata", 32'(rv), 32'(ref_mem[11'h5A7]));
      @(negedge clk);
      start_wr = 1'b1; addr = 11'h123; wdata = 8'h77;
      @(posedge clk); #1;
      start_wr = 1'b0;
      repeat ((12 * 4 + 2) * CLK_DIV) @(posedge clk);
      #1;
      chk("mid_addr/busy", 32'(busy), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort/scl", 32'(scl), 32'd1);
      chk("abort/sda", 32'(sda), 32'd1);
      chk("abort/busy", 32'(busy), 32'd0);
      chk("abort/done", 32'(done), 32'd0);
      chk("abort/ack_err", 32'(ack_err), 32'd0);
      chk("abort/rdata", 32'(rdata), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      chk("abort/mem", 32'(mem[11'h123]), 32'(ref_mem[11'h123]));

      run_txn("post_wr", 1'b1, 1'b0, 11'h010, 8'h3C, WR_LAT, 1'b0, -1, rv);
      ref_mem[11'h010] = 8'h3C;
      chk("post_wr/mem", 32'(mem[11'h010]), 32'h3C);
      run_txn("post_rd", 1'b0, 1'b1, 11'h010, 8'h00, RD_LAT, 1'b0, -1, rv);
      chk("post_rd/rdata", 32'(rv), 32'h3C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
